// File: rtl/if_id_fifo_pkg.sv
// Shared pipeline default constants and the IF/ID buffer package.
// INST_NOP is the canonical ADDI x0,x0,0 bubble; PC_RST is the core reset vector.
// The package mirrors the defines as typed constants for parameter defaults.
`ifndef PIPELINE_DEFINES_SVH
`define PIPELINE_DEFINES_SVH
`define INST_NOP 32'h0000_0013
`define PC_RST   32'h8000_0000
`endif

package if_id_fifo_pkg;
  localparam logic [31:0] INST_NOP_C = `INST_NOP;
  localparam logic [31:0] PC_RST_C   = `PC_RST;
endpackage

// File: rtl/if_id_fifo_mem.sv
// Record storage for the IF/ID buffer: DEPTH x DW flops, one write, one read port.
// Latency: write lands on the clock edge; read is combinational from rd_addr.
// Backpressure: none here; the caller qualifies wr_en. Contents are never reset.
module if_id_fifo_mem #(
  parameter int DW    = 96,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DW-1:0]            wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DW-1:0]            rd_data
);

  logic [DW-1:0] r_mem [DEPTH];

  // Synchronous write of one record
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/if_id_fifo.sv
// Show-ahead fetch-to-decode buffer of {instr, pc, pc_plus4} records with flush.
// Latency: a record pushed on edge N is visible at the head in cycle N+1 (no bypass).
// Backpressure: in_ready drops only when full and never depends on out_ready.
module if_id_fifo
  import if_id_fifo_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter int               DEPTH      = 4,
  parameter logic [WIDTH-1:0] NOP_VAL    = WIDTH'(INST_NOP_C),
  parameter logic [WIDTH-1:0] PC_DEFAULT = WIDTH'(PC_RST_C)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         instr_in,
  input  logic [WIDTH-1:0]         pc_in,
  input  logic [WIDTH-1:0]         pc_plus4_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         instr_out,
  output logic [WIDTH-1:0]         pc_out,
  output logic [WIDTH-1:0]         pc_plus4_out,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic                 w_push;
  logic                 w_pop;
  logic [3*WIDTH-1:0]   w_wr_dat;
  logic [3*WIDTH-1:0]   w_rd_dat;

  // Ready/valid come straight from the occupancy counter so neither side
  // sees a combinational path through the other.
  assign in_ready  = (r_count != FULL_CNT);
  assign out_valid = (r_count != '0);

  // Flush wins over both handshakes; a same-cycle push is dropped.
  assign w_push = in_valid & in_ready & ~flush;
  assign w_pop  = out_valid & out_ready & ~flush;

  assign w_wr_dat = {instr_in, pc_in, pc_plus4_in};

  if_id_fifo_mem #(
    .DW    (3 * WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (w_push),
    .wr_addr (r_wr_ptr),
    .wr_data (w_wr_dat),
    .rd_addr (r_rd_ptr),
    .rd_data (w_rd_dat)
  );

  // Pointer advance; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end

  // Occupancy: +push -pop, cleared by flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head record, or a NOP bubble at the reset PC when nothing is buffered,
  // so decode never sees stale memory contents.
  always_comb begin
    instr_out    = NOP_VAL;
    pc_out       = PC_DEFAULT;
    pc_plus4_out = PC_DEFAULT;
    if (out_valid) begin
      instr_out    = w_rd_dat[3*WIDTH-1:2*WIDTH];
      pc_out       = w_rd_dat[2*WIDTH-1:WIDTH];
      pc_plus4_out = w_rd_dat[WIDTH-1:0];
    end
  end

  assign count = r_count;

endmodule

// File: tb/tb_if_id_fifo.sv
module tb_if_id_fifo;
  import if_id_fifo_pkg::*;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr_in = '0;
  logic [31:0] pc_in = '0;
  logic [31:0] pc_plus4_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4_out;
  logic [2:0]  count;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_pops = 0;
  bit   done = 1'b0;
  rec_t exp_q[$];

  always #5 clk = ~clk;

  if_id_fifo dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .instr_in     (instr_in),
    .pc_in        (pc_in),
    .pc_plus4_in  (pc_plus4_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .instr_out    (instr_out),
    .pc_out       (pc_out),
    .pc_plus4_out (pc_plus4_out),
    .count        (count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic rec_t mk(input logic [31:0] pc);
    rec_t r;
    r.pc    = pc;
    r.instr = pc ^ 32'hA5A5_0000;
    r.pc4   = pc + 32'd4;
    return r;
  endfunction

  // Present a record on the IF side (does not itself imply acceptance)
  task automatic drive(input logic [31:0] pc);
    rec_t r;
    r = mk(pc);
    in_valid    = 1'b1;
    instr_in    = r.instr;
    pc_in       = r.pc;
    pc_plus4_in = r.pc4;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: on every negedge, a consumed head must match the scoreboard,
  // and an empty head must show the bubble defaults.
  always @(negedge clk) begin
    if (!done) begin
      if (out_valid && out_ready && !flush && rst_n) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL pop_unexpected: got pc 0x%08h expected no record", pc_out);
        end else begin
          rec_t e;
          e = exp_q.pop_front();
          n_pops++;
          chk("pop_pc", pc_out, e.pc);
          chk("pop_instr", instr_out, e.instr);
          chk("pop_pc4", pc_plus4_out, e.pc4);
        end
      end else if (!out_valid) begin
        chk("idle_instr", instr_out, INST_NOP_C);
        chk("idle_pc", pc_out, PC_RST_C);
        chk("idle_pc4", pc_plus4_out, PC_RST_C);
      end
    end
  end

  initial begin
    // Reset then idle
    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", instr_out, 32'h0000_0013);
    chk("rst_pc", pc_out, 32'h8000_0000);
    chk("rst_pc4", pc_plus4_out, 32'h8000_0000);
    step();
    rst_n = 1'b1;
    step();

    // Fill to DEPTH with decode stalled
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(32'h100 + 32'(4 * i));
      exp_q.push_back(mk(32'h100 + 32'(4 * i)));
      step();
    end
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    drive(32'h110);
    step();
    chk("held_count", 32'(count), 32'd4);
    chk("held_head_pc", pc_out, 32'h100);

    // Pop from full while push is blocked
    out_ready = 1'b1;
    step();
    chk("pop_full_count", 32'(count), 32'd3);
    chk("pop_full_in_ready", 32'(in_ready), 32'd1);
    exp_q.push_back(mk(32'h110));
    step();
    in_valid = 1'b0;
    chk("push_pop_count", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) step();
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_out_valid", 32'(out_valid), 32'd0);

    // Push into empty: no same-cycle bypass
    drive(32'h200);
    #2;
    chk("bypass_out_valid", 32'(out_valid), 32'd0);
    exp_q.push_back(mk(32'h200));
    step();
    in_valid = 1'b0;
    chk("lat_out_valid", 32'(out_valid), 32'd1);
    chk("lat_pc", pc_out, 32'h200);
    chk("lat_pc4", pc_plus4_out, 32'h204);
    step();
    chk("lat_count", 32'(count), 32'd0);

    // Flush with three buffered and a simultaneous push
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(32'h280 + 32'(4 * i));
      exp_q.push_back(mk(32'h280 + 32'(4 * i)));
      step();
    end
    chk("pre_flush_count", 32'(count), 32'd3);
    flush = 1'b1;
    drive(32'h300);
    step();
    flush = 1'b0;
    exp_q.delete();
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_instr", instr_out, 32'h0000_0013);
    chk("flush_pc", pc_out, 32'h8000_0000);
    drive(32'h400);
    exp_q.push_back(mk(32'h400));
    step();
    in_valid = 1'b0;
    chk("post_flush_count", 32'(count), 32'd1);
    chk("post_flush_pc", pc_out, 32'h400);
    out_ready = 1'b1;
    step();
    step();

    // Asynchronous reset mid-cycle with two entries
    out_ready = 1'b0;
    drive(32'h500);
    exp_q.push_back(mk(32'h500));
    step();
    drive(32'h504);
    exp_q.push_back(mk(32'h504));
    step();
    in_valid = 1'b0;
    chk("pre_rst_count", 32'(count), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_pc", pc_out, 32'h8000_0000);
    exp_q.delete();
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(32'h600);
    exp_q.push_back(mk(32'h600));
    step();
    in_valid = 1'b0;
    chk("post_rst_pc", pc_out, 32'h600);
    step();
    step();

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("total_pops", 32'(n_pops), 32'd8);
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
